pipelined_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder with valid/ready handshakes on input and output. It generalises the single-bit full adder to WIDTH-bit operands. The carry chain is split into STAGES registered slices, so it can sit inside datapaths clocked faster than a full-width ripple allows. It is the arithmetic building block for the accumulator and ALU work that follows.

---
 rtl/adder_pkg.sv | 38 +++
 rtl/pipelined_adder_if.sv | 38 +++
 rtl/adder_slice.sv | 31 +++
 rtl/pipelined_adder.sv | 146 ++++++++++++++
 tb/tb_pipelined_adder.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared types and elaboration helpers for pipelined_adder.
// Optional feature macro: ADDER_OVF_EN (adds the registered overflow bit to
// the stage record).
package adder_pkg;

  // Widest operand the stage record can carry.
  localparam int MAX_WIDTH = 64;

  // One pipeline stage's registered contents. Vectors are sized for the
  // widest build; a given instance uses bits [WIDTH-1:0] only.
  typedef struct packed {
    logic                 valid;  // stage holds a real beat
    logic                 carry;  // carry out of the highest slice added so far
`ifdef ADDER_OVF_EN
    logic                 ovf;    // signed overflow, meaningful in the last stage
`endif
    logic [MAX_WIDTH-1:0] sum;    // sum chunks already produced, in place
    logic [MAX_WIDTH-1:0] a_rem;  // operand A chunks still to be added, in place
    logic [MAX_WIDTH-1:0] b_rem;  // operand B chunks still to be added, in place
  } stage_reg_t;

  // Width of each slice of the carry chain.
  function automatic int chunk_width(input int width, input int stages);
    if (stages < 32'sd1) begin
      return width;
    end else begin
      return width / stages;
    end
  endfunction

  // True when the WIDTH/STAGES pair can be built: positive sizes, slices of
  // equal width, and operands that fit the stage record.
  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 32'sd1) && (stages >= 32'sd1) &&
           (width <= MAX_WIDTH) && ((width % stages) == 32'sd0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand-in / result-out handshake bundle of the adder.
// Optional feature macro: ADDER_OVF_EN (adds the OVF result bit).
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);

  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_I;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] S;
  logic             C_O;
`ifdef ADDER_OVF_EN
  logic             OVF;
`endif

  // Producer of operands and consumer of results.
  modport master (
    output IN_VALID, A, B, C_I, OUT_READY,
`ifdef ADDER_OVF_EN
    input  OVF,
`endif
    input  IN_READY, OUT_VALID, S, C_O
  );

  // The adder itself.
  modport slave (
    input  IN_VALID, A, B, C_I, OUT_READY,
`ifdef ADDER_OVF_EN
    output OVF,
`endif
    output IN_READY, OUT_VALID, S, C_O
  );

endinterface

// File: rtl/adder_slice.sv
// adder_slice: purely combinational CW-bit ripple adder, one slice of the
// pipelined carry chain.
// Optional feature macro: ADDER_OVF_EN (exposes c_msb, the carry into the
// slice's top bit, needed for signed overflow in the final slice).
module adder_slice #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          c_i,
`ifdef ADDER_OVF_EN
  output logic          c_msb,
`endif
  output logic [CW-1:0] s,
  output logic          c_o
);

  logic [CW:0] w_sum;

  // CW+1-bit add: low CW bits are the chunk, the top bit is the slice carry.
  assign w_sum = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, c_i};
  assign s     = w_sum[CW-1:0];
  assign c_o   = w_sum[CW];

`ifdef ADDER_OVF_EN
  // The carry into the top bit is recovered from that bit's sum and operands,
  // which also holds for a one-bit slice.
  assign c_msb = w_sum[CW-1] ^ a[CW-1] ^ b[CW-1];
`endif

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit ripple-carry adder whose carry chain is cut into
// STAGES registered slices, with valid/ready handshakes on both sides. The
// whole pipeline advances together whenever the output is empty or being
// taken, so a stall holds every stage and bubbles travel as bubbles.
// Optional feature macro: ADDER_OVF_EN (registered signed-overflow output OVF).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic         CLK,
  input logic         RST,
  pipelined_adder_if.slave io_bus
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be 1..%0d and a multiple of STAGES", MAX_WIDTH);
  end

  // Registered stages; r_stage[STAGES-1] drives the result port.
  stage_reg_t       r_stage [STAGES];
  stage_reg_t       w_next  [STAGES];

  // What each slice sees: operands, sum-so-far, carry-in and valid of the
  // beat about to enter that stage.
  logic [WIDTH-1:0] w_src_a   [STAGES];
  logic [WIDTH-1:0] w_src_b   [STAGES];
  logic [WIDTH-1:0] w_src_sum [STAGES];
  logic             w_src_c   [STAGES];
  logic             w_src_v   [STAGES];

  // Slice results.
  logic [CW-1:0]    w_chunk_s [STAGES];
  logic             w_chunk_c [STAGES];
`ifdef ADDER_OVF_EN
  logic             w_chunk_m [STAGES];
`endif

  logic             w_en;
  logic [WIDTH-1:0] w_pos;
  logic [WIDTH-1:0] w_a_left;
  logic [WIDTH-1:0] w_b_left;
  logic [STAGES-1:0] w_unused_stage;

  // Global advance: the last stage is empty or its result is being taken.
  assign w_en = (~r_stage[STAGES-1].valid) | io_bus.OUT_READY;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    if (k == 0) begin : g_head
      // The head slice takes operands straight from the input beat; empty
      // beats load zeros so idle operand values never enter the pipeline.
      assign w_src_a[k]   = io_bus.IN_VALID ? io_bus.A : {WIDTH{1'b0}};
      assign w_src_b[k]   = io_bus.IN_VALID ? io_bus.B : {WIDTH{1'b0}};
      assign w_src_sum[k] = {WIDTH{1'b0}};
      assign w_src_c[k]   = io_bus.IN_VALID & io_bus.C_I;
      assign w_src_v[k]   = io_bus.IN_VALID;
    end else begin : g_tail
      // Later slices continue from the previous stage's registers.
      assign w_src_a[k]   = r_stage[k-1].a_rem[WIDTH-1:0];
      assign w_src_b[k]   = r_stage[k-1].b_rem[WIDTH-1:0];
      assign w_src_sum[k] = r_stage[k-1].sum[WIDTH-1:0];
      assign w_src_c[k]   = r_stage[k-1].carry;
      assign w_src_v[k]   = r_stage[k-1].valid;
    end

    adder_slice #(
      .CW (CW)
    ) u_slice (
      .a     (w_src_a[k][k*CW +: CW]),
      .b     (w_src_b[k][k*CW +: CW]),
      .c_i   (w_src_c[k]),
`ifdef ADDER_OVF_EN
      .c_msb (w_chunk_m[k]),
`endif
      .s     (w_chunk_s[k]),
      .c_o   (w_chunk_c[k])
    );
  end

  // Build each stage's next contents: drop the new chunk into place beside the
  // lower chunks and retire the operand chunks this slice has consumed.
  always_comb begin
    w_pos    = {WIDTH{1'b0}};
    w_a_left = {WIDTH{1'b0}};
    w_b_left = {WIDTH{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      w_pos                   = {WIDTH{1'b0}};
      w_pos[k*CW +: CW]       = w_chunk_s[k];
      w_a_left                = w_src_a[k];
      w_a_left[k*CW +: CW]    = {CW{1'b0}};
      w_b_left                = w_src_b[k];
      w_b_left[k*CW +: CW]    = {CW{1'b0}};

      w_next[k]                  = '0;
      w_next[k].valid            = w_src_v[k];
      w_next[k].carry            = w_chunk_c[k];
      w_next[k].sum[WIDTH-1:0]   = w_src_sum[k] | w_pos;
      w_next[k].a_rem[WIDTH-1:0] = w_a_left;
      w_next[k].b_rem[WIDTH-1:0] = w_b_left;
`ifdef ADDER_OVF_EN
      // Signed overflow only exists once the top slice has been added.
      if (k == STAGES - 1) begin
        w_next[k].ovf = w_chunk_m[k] ^ w_chunk_c[k];
      end else begin
        w_next[k].ovf = 1'b0;
      end
`endif
    end
  end

  // All stages move in lock-step on w_en; reset empties and zeroes every stage,
  // discarding any beat in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= w_next[k];
      end
    end
  end

  // Fold the stage records into a sink: the record is sized for the widest
  // build and the last stage's operand fields are always empty.
  always_comb begin
    w_unused_stage = {STAGES{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      w_unused_stage[k] = ^r_stage[k];
    end
  end

  // Ready is the advance condition itself, the only combinational output path.
  assign io_bus.IN_READY  = w_en;
  assign io_bus.OUT_VALID = r_stage[STAGES-1].valid;
  assign io_bus.S         = r_stage[STAGES-1].sum[WIDTH-1:0];
  assign io_bus.C_O       = r_stage[STAGES-1].carry;
`ifdef ADDER_OVF_EN
  assign io_bus.OVF       = r_stage[STAGES-1].ovf;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: self-checking bench for pipelined_adder. Three instances
// (16/4, 8/1, 8/8) share one stimulus stream; a queue-based scoreboard per
// instance predicts every result from plain integer arithmetic and checks
// value and stall-adjusted latency. Honours ADDER_OVF_EN when defined.
module tb_pipelined_adder;

  localparam int ND    = 3;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(16)) bus0 ();
  pipelined_adder_if #(.WIDTH(8))  bus1 ();
  pipelined_adder_if #(.WIDTH(8))  bus2 ();

  assign bus0.IN_VALID = in_valid;  assign bus0.OUT_READY = out_ready;
  assign bus0.A = a;                assign bus0.B = b;          assign bus0.C_I = ci;
  assign bus1.IN_VALID = in_valid;  assign bus1.OUT_READY = out_ready;
  assign bus1.A = a[7:0];           assign bus1.B = b[7:0];     assign bus1.C_I = ci;
  assign bus2.IN_VALID = in_valid;  assign bus2.OUT_READY = out_ready;
  assign bus2.A = a[7:0];           assign bus2.B = b[7:0];     assign bus2.C_I = ci;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut0 (.CLK(clk), .RST(rst), .io_bus(bus0));
  pipelined_adder #(.WIDTH(8),  .STAGES(1)) u_dut1 (.CLK(clk), .RST(rst), .io_bus(bus1));
  pipelined_adder #(.WIDTH(8),  .STAGES(8)) u_dut2 (.CLK(clk), .RST(rst), .io_bus(bus2));

  // Uniform per-instance views for the scoreboard.
  logic        dv_in_r  [ND];
  logic        dv_out_v [ND];
  logic [15:0] dv_s     [ND];
  logic        dv_co    [ND];
  logic        dv_ovf   [ND];
  assign dv_in_r[0] = bus0.IN_READY;  assign dv_out_v[0] = bus0.OUT_VALID;
  assign dv_in_r[1] = bus1.IN_READY;  assign dv_out_v[1] = bus1.OUT_VALID;
  assign dv_in_r[2] = bus2.IN_READY;  assign dv_out_v[2] = bus2.OUT_VALID;
  assign dv_s[0] = bus0.S;  assign dv_s[1] = {8'h00, bus1.S};  assign dv_s[2] = {8'h00, bus2.S};
  assign dv_co[0] = bus0.C_O;  assign dv_co[1] = bus1.C_O;  assign dv_co[2] = bus2.C_O;
`ifdef ADDER_OVF_EN
  assign dv_ovf[0] = bus0.OVF;  assign dv_ovf[1] = bus1.OVF;  assign dv_ovf[2] = bus2.OVF;
`else
  assign dv_ovf[0] = 1'b0;      assign dv_ovf[1] = 1'b0;      assign dv_ovf[2] = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ovf;
    int          acc_cyc;
    int          acc_stall;
  } exp_t;

  exp_t fifo [ND][DEPTH];
  int   wr_ptr    [ND];
  int   rd_ptr    [ND];
  int   stall_cnt [ND];

  function automatic int width_of(input int d);
    case (d)
      0:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int stages_of(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  // Reference: plain integer sum of the masked operands and carry-in.
  function automatic exp_t model(input int w, input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
    exp_t        e;
    int unsigned mask;
    int unsigned full;
    logic        sa, sb, ss;
    mask = (32'd1 << w) - 32'd1;
    full = (32'(ta) & mask) + (32'(tb_) & mask) + 32'(tc);
    e     = '0;
    e.s   = 16'(full & mask);
    e.co  = 1'((full >> w) & 32'd1);
    sa    = ta[w-1];
    sb    = tb_[w-1];
    ss    = e.s[w-1];
    e.ovf = (sa == sb) && (ss != sa);
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h required 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat on the main instance and hold it until it is taken.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
    int guard;
    guard    = 0;
    a        = ta;
    b        = tb_;
    ci       = tc;
    in_valid = 1'b1;
    @(negedge clk);
    while (!bus0.IN_READY && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("accept", 64'(bus0.IN_READY), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Scoreboard: log accepted beats, match handshaken results in order,
  // and check latency net of stall cycles.
  initial begin
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      wr_ptr[d] = 0; rd_ptr[d] = 0; stall_cnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (rst) begin
          wr_ptr[d] = 0; rd_ptr[d] = 0; stall_cnt[d] = 0;
        end else begin
          if (dv_out_v[d] && out_ready) begin
            check_eq($sformatf("d%0d_out_pending", d), 64'(wr_ptr[d] != rd_ptr[d]), 64'd1);
            if (wr_ptr[d] != rd_ptr[d]) begin
              e = fifo[d][rd_ptr[d] % DEPTH];
              rd_ptr[d]++;
              check_eq($sformatf("d%0d_sum", d), 64'(dv_s[d]), 64'(e.s));
              check_eq($sformatf("d%0d_cout", d), 64'(dv_co[d]), 64'(e.co));
`ifdef ADDER_OVF_EN
              check_eq($sformatf("d%0d_ovf", d), 64'(dv_ovf[d]), 64'(e.ovf));
`endif
              check_eq($sformatf("d%0d_latency", d),
                       64'(cyc - e.acc_cyc - (stall_cnt[d] - e.acc_stall)), 64'(stages_of(d)));
            end
          end
          if (in_valid && dv_in_r[d]) begin
            e           = model(width_of(d), a, b, ci);
            e.acc_cyc   = cyc;
            e.acc_stall = stall_cnt[d];
            fifo[d][wr_ptr[d] % DEPTH] = e;
            wr_ptr[d]++;
          end
          if (dv_out_v[d] && !out_ready) begin
            stall_cnt[d]++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 16'h0000; b = 16'h0000; ci = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, while reset is held and after release.
    @(negedge clk);
    check_eq("rst_out_valid", 64'(bus0.OUT_VALID), 64'd0);
    check_eq("rst_sum", 64'(bus0.S), 64'd0);
    check_eq("rst_cout", 64'(bus0.C_O), 64'd0);
    check_eq("rst_in_ready", 64'(bus0.IN_READY), 64'd1);
`ifdef ADDER_OVF_EN
    check_eq("rst_ovf", 64'(bus0.OVF), 64'd0);
`endif
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_valid", 64'(bus0.OUT_VALID), 64'd0);
    check_eq("post_rst_ready", 64'(bus0.IN_READY), 64'd1);
    check_eq("post_rst_valid8", 64'(bus2.OUT_VALID), 64'd0);
    tick();

    // Full-width carry ripple.
    send(16'hFFFF, 16'h0001, 1'b0);
    repeat (6) tick();

    // Back-to-back streaming.
    for (int i = 0; i < 8; i++) begin
      send(16'(i), 16'(2 * i), 1'(i & 1));
    end
    repeat (10) tick();

    // Overflow corners.
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    repeat (10) tick();

    // Stall with S=0x1234 at the output and a second beat behind it.
    send(16'h1000, 16'h0234, 1'b0);
    send(16'h0001, 16'h0001, 1'b1);
    out_ready = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!bus0.OUT_VALID && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check_eq("stall_valid", 64'(bus0.OUT_VALID), 64'd1);
      check_eq("stall_sum", 64'(bus0.S), 64'h1234);
      check_eq("stall_cout", 64'(bus0.C_O), 64'd0);
      check_eq("stall_in_ready", 64'(bus0.IN_READY), 64'd0);
    end
    tick();
    out_ready = 1'b1;
    repeat (12) tick();

    // Reset with three beats in flight.
    send(16'h0011, 16'h0022, 1'b0);
    send(16'h0033, 16'h0044, 1'b1);
    send(16'h0055, 16'h0066, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", 64'(bus0.OUT_VALID), 64'd0);
    check_eq("midrst_sum", 64'(bus0.S), 64'd0);
    check_eq("midrst_cout", 64'(bus0.C_O), 64'd0);
    check_eq("midrst_ready", 64'(bus0.IN_READY), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      check_eq("midrst_no_stale", 64'(bus0.OUT_VALID | bus1.OUT_VALID | bus2.OUT_VALID), 64'd0);
    end
    tick();

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = pick();
      b         = pick();
      ci        = 1'($urandom_range(0, 1));
      tick();
    end

    // Drain and confirm every accepted beat came out.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("d%0d_drained", d), 64'(wr_ptr[d] - rd_ptr[d]), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
